double_dabble_converter: RTL and testbench
==========================================

DOUBLE_DABBLE_CONVERTER -- requirements
Module: double_dabble_converter

Interface
REQ-001 Parameter W, default 27, meaning binary input width in bits (W >= 4).
REQ-002 Parameter DIGITS, default 8, meaning number of packed BCD output digits.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  conversion request, sampled on rising edge of clock.
REQ-006 bin_in  input  W  unsigned binary value, sampled only when start is accepted.
REQ-007 bcd_out  output  4*DIGITS  packed BCD result; digit 0 (least significant) in bits [3:0]; feeds the 7-segment driver BCD_in port.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle pulse marking a new bcd_out value.
REQ-010 overflow  output  1  high when the last accepted bin_in exceeded 10^DIGITS - 1.

Function
REQ-011 FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1, the block SHALL latch bin_in into a W-bit shift register, clear the working BCD register, clear the bit counter, and enter SHIFT.
REQ-013 Each SHIFT cycle SHALL add 3 to every working digit >= 5, then shift {working BCD, shift register} left by one bit.
REQ-014 The bit shifted out of the most significant working digit SHALL be discarded, giving a result of bin_in mod 10^DIGITS.
REQ-015 SHIFT SHALL last exactly W cycles, then enter DONE.
REQ-016 DONE SHALL register the working BCD into bcd_out, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: done and the new bcd_out SHALL become visible W+1 cycles after the edge on which start was accepted.
REQ-018 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored whenever busy=1; there is no queueing and bin_in changes during conversion have no effect.
REQ-020 bcd_out and overflow SHALL hold their last values between conversions.
REQ-021 start held high continuously SHALL produce back-to-back conversions, one every W+2 cycles.
REQ-022 Every bcd_out nibble SHALL be in the range 0-9 at all times.

Reset
REQ-023 When reset is asserted, the FSM SHALL go to IDLE immediately, independent of clock.
REQ-024 While reset is asserted, bcd_out, busy, done, overflow, the counter, and the working registers SHALL be 0.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse, and bcd_out SHALL read 0 afterwards.

Configuration
REQ-026 Macro OVERFLOW_SAT_EN: when defined, overflow SHALL be computed at accept time as (bin_in >= 10^DIGITS) and latched. If overflow is set, the DONE state SHALL load all-9 digits into bcd_out instead of the modulo result.
REQ-027 When OVERFLOW_SAT_EN is not defined, overflow SHALL be tied to 0, no comparator SHALL be built, and bcd_out SHALL be the modulo result per REQ-014.

Verification (W=27, DIGITS=8)
REQ-028 Reset then idle -> bcd_out=0x00000000, busy=0, done=0, overflow=0.
REQ-029 start one cycle with bin_in=388176 -> done pulses 28 cycles later, bcd_out=0x00388176, busy high for 28 cycles.
REQ-030 Conversions of 0 and 99999999 -> bcd_out=0x00000000, then 0x99999999, with overflow=0.
REQ-031 bin_in=123456789 -> with OVERFLOW_SAT_EN: bcd_out=0x99999999, overflow=1; without it: bcd_out=0x23456789, overflow=0.
REQ-032 start pulsed again at cycle 5 of a conversion with a different bin_in -> ignored; first result unchanged, exactly one done pulse.
REQ-033 reset asserted at cycle 10 of a conversion of 388176 -> outputs 0 immediately, no done pulse; a new start after release converts correctly.

Source files
------------

// File: rtl/double_dabble_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter: one bit per cycle, result mod 10^DIGITS.
// Optional macro OVERFLOW_SAT_EN: latch (bin_in >= 10^DIGITS) and saturate the result to all nines.
module double_dabble_converter #(
  parameter int W      = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          sr_q, sr_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Add-3 correction on every digit >= 5, then shift left one bit bringing in_bit
  // into digit 0; the carry out of the top digit is dropped (modulo behaviour).
  function automatic logic [4*DIGITS-1:0] dabble_shift(input logic [4*DIGITS-1:0] v,
                                                       input logic in_bit);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d;
    logic                cin;
    r   = '0;
    cin = in_bit;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      r[4*i +: 4] = {d[2:0], cin};
      cin = d[3];
    end
    return r;
  endfunction

`ifdef OVERFLOW_SAT_EN
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef OVERFLOW_SAT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin_in;
          work_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef OVERFLOW_SAT_EN
          ovf_d   = (64'(bin_in) >= LIMIT);
`endif
        end
      end
      SHIFT: begin
        work_d = dabble_shift(work_q, sr_q[W-1]);
        sr_d   = {sr_q[W-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = DONE;
      end
      DONE: begin
`ifdef OVERFLOW_SAT_EN
        bcd_d  = ovf_q ? {DIGITS{4'h9}} : work_q;
`else
        bcd_d  = work_q;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OVERFLOW_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bcd_out = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef OVERFLOW_SAT_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_double_dabble_converter.sv
// Scoreboard bench for double_dabble_converter (W=27, DIGITS=8): stimulus pushes expected
// results, an independent monitor pops and compares on every done pulse.
module tb_double_dabble_converter;
  localparam int W      = 27;
  localparam int DIGITS = 8;
`ifdef OVERFLOW_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [W-1:0]        bin_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic                busy;
  logic                done;
  logic                overflow;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          busy_run = 0;
  logic [31:0] last_bcd;

  double_dabble_converter #(.W(W), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop on every done pulse, check data, overflow, latency and busy length.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      busy_run = 0;
    end else begin
      logic bad;
      exp_t e;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
        if (bcd_out[4*i +: 4] > 4'd9) bad = 1'b1;
      chk("digit_range", longint'(bad), 0);
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("bcd_out", longint'(bcd_out), longint'(e.bcd));
          chk("overflow", longint'(overflow), longint'(e.ovf));
          chk("done_latency", longint'(cyc), longint'(e.cyc));
          chk("busy_cycles", longint'(busy_run), longint'(W + 1));
        end
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] v, input logic [31:0] eb, input logic eo);
    @(negedge clock);
    start  = 1'b1;
    bin_in = v;
    sb.push_back('{eb, eo, cyc + 1 + W + 1});
    last_bcd = eb;
    @(negedge clock);
    start  = 1'b0;
    bin_in = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 4 * W) begin
      @(negedge clock);
      n++;
    end
    if (busy || sb.size() != 0) chk("idle_timeout", 1, 0);
    @(negedge clock);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_bcd", longint'(bcd_out), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ovf", longint'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_bcd", longint'(bcd_out), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_ovf", longint'(overflow), 0);

    issue(27'd388176, 32'h00388176, 1'b0);
    wait_idle();
    repeat (3) @(negedge clock);
    chk("hold_bcd", longint'(bcd_out), longint'(last_bcd));

    issue(27'd0,         32'h00000000, 1'b0);
    wait_idle();
    issue(27'd99999999,  32'h99999999, 1'b0);
    wait_idle();
    issue(27'd123456789, SAT ? 32'h99999999 : 32'h23456789, SAT);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("hold_ovf", longint'(overflow), longint'(SAT));
    issue(27'd134217727, SAT ? 32'h99999999 : 32'h34217727, SAT);
    wait_idle();
    issue(27'd100000000, SAT ? 32'h99999999 : 32'h00000000, SAT);
    wait_idle();
    issue(27'd9,  32'h00000009, 1'b0);
    wait_idle();
    issue(27'd10, 32'h00000010, 1'b0);
    wait_idle();

    // Second start during a conversion must be ignored.
    issue(27'd5, 32'h00000005, 1'b0);
    repeat (3) @(negedge clock);
    start  = 1'b1;
    bin_in = 27'd777;
    @(negedge clock);
    start  = 1'b0;
    wait_idle();
    repeat (W + 4) @(negedge clock);

    // start held high: back-to-back conversions every W+2 cycles.
    @(negedge clock);
    start  = 1'b1;
    bin_in = 27'd12345;
    sb.push_back('{32'h00012345, 1'b0, cyc + 1 + W + 1});
    @(negedge clock);
    bin_in = 27'd67108864;
    sb.push_back('{32'h67108864, 1'b0, cyc + W + 2 + W + 1});
    repeat (W + 2) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset at cycle 10 of a conversion aborts it with no done pulse.
    issue(27'd388176, 32'h00388176, 1'b0);
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_bcd", longint'(bcd_out), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (W + 5) @(negedge clock);
    chk("after_abort_bcd", longint'(bcd_out), 0);
    chk("after_abort_busy", longint'(busy), 0);
    issue(27'd388176, 32'h00388176, 1'b0);
    wait_idle();

    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
